// File: rtl/dvi_timing_ctrl.sv
// Raster sequencer for three TMDS encoder channels: counters, pixel request, DE and sync
// generation from a runtime-loadable timing set that swaps in only at frame boundaries.
module dvi_timing_ctrl #(
    parameter int unsigned CW       = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_SS     = 656,
    parameter int unsigned H_SE     = 752,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_SS     = 490,
    parameter int unsigned V_SE     = 492,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic            pix_clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    output logic            cfg_err,
    output logic            pix_req,
    output logic [CW-1:0]   pix_x,
    output logic [CW-1:0]   pix_y,
    output logic            de,
    output logic            hsync,
    output logic            vsync,
    output logic            frame_start,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [4*CW-1:0] HDef = {CW'(H_TOTAL), CW'(H_SE), CW'(H_SS), CW'(H_ACTIVE)};
    localparam logic [4*CW-1:0] VDef = {CW'(V_TOTAL), CW'(V_SE), CW'(V_SS), CW'(V_ACTIVE)};

    // Field order within a timing word: {total, sync_end, sync_start, active}.
    function automatic logic cfg_legal(logic [4*CW-1:0] c, logic [CW-1:0] min_total);
        logic [CW-1:0] act, ss, se, tot;
        act = c[CW-1:0];
        ss  = c[2*CW-1:CW];
        se  = c[3*CW-1:2*CW];
        tot = c[4*CW-1:3*CW];
        return (act != '0) && (act <= ss) && (ss < se) && (se <= tot) && (tot >= min_total);
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [4*CW-1:0] act_h_q, act_h_d, act_v_q, act_v_d;
    logic [4*CW-1:0] sh_h_q, sh_h_d, sh_v_q, sh_v_d;
    logic            sh_full_q, sh_full_d;
    logic            cfg_err_q, cfg_err_d;
    logic            req_q, req_d;
    logic [CW-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic            hs1_q, hs1_d, vs1_q, vs1_d;
    logic            de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

    logic [CW-1:0]   h_act, h_ss, h_se, h_tot, v_act, v_ss, v_se, v_tot;
    logic            running, h_last, v_last, frame_end, hs_fire, cfg_ok, apply;

    assign {h_tot, h_se, h_ss, h_act} = act_h_q;
    assign {v_tot, v_se, v_ss, v_act} = act_v_q;

    always_comb begin
        running   = (state_q != StIdle);
        h_last    = (h_cnt_q == h_tot - CW'(1));
        v_last    = (v_cnt_q == v_tot - CW'(1));
        frame_end = running && h_last && v_last;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StDrain;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // IDLE parks the raster at the origin so every start begins at (0,0).
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (running && !h_last) begin
            h_cnt_d = h_cnt_q + CW'(1);
            v_cnt_d = v_cnt_q;
        end else if (running && !v_last) begin
            v_cnt_d = v_cnt_q + CW'(1);
        end

        hs_fire = cfg_valid && !sh_full_q;
        cfg_ok  = cfg_legal(cfg_h, CW'(4)) && cfg_legal(cfg_v, CW'(2));
        apply   = sh_full_q && (frame_end || !running);

        sh_full_d = sh_full_q;
        sh_h_d    = sh_h_q;
        sh_v_d    = sh_v_q;
        act_h_d   = act_h_q;
        act_v_d   = act_v_q;
        if (apply) begin
            act_h_d   = sh_h_q;
            act_v_d   = sh_v_q;
            sh_full_d = 1'b0;
        end
        // Handshake and apply are exclusive: an offer is only taken while the slot is empty.
        if (hs_fire && cfg_ok) begin
            sh_h_d    = cfg_h;
            sh_v_d    = cfg_v;
            sh_full_d = 1'b1;
        end
        cfg_err_d = hs_fire && !cfg_ok;

        req_d   = running && (h_cnt_q < h_act) && (v_cnt_q < v_act);
        pix_x_d = req_d ? h_cnt_q : pix_x_q;
        pix_y_d = req_d ? v_cnt_q : pix_y_q;
        hs1_d   = running && (h_cnt_q >= h_ss) && (h_cnt_q < h_se);
        vs1_d   = running && (v_cnt_q >= v_ss) && (v_cnt_q < v_se);

        de_d    = req_q;
        hsync_d = hs1_q;
        vsync_d = vs1_q;
        fs_d    = req_q && (pix_x_q == '0) && (pix_y_q == '0);
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            act_h_q   <= HDef;
            act_v_q   <= VDef;
            sh_h_q    <= '0;
            sh_v_q    <= '0;
            sh_full_q <= 1'b0;
            cfg_err_q <= 1'b0;
            req_q     <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            act_h_q   <= act_h_d;
            act_v_q   <= act_v_d;
            sh_h_q    <= sh_h_d;
            sh_v_q    <= sh_v_d;
            sh_full_q <= sh_full_d;
            cfg_err_q <= cfg_err_d;
            req_q     <= req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            fs_q      <= fs_d;
        end
    end

    assign cfg_ready   = !sh_full_q;
    assign cfg_err     = cfg_err_q;
    assign pix_req     = req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign busy        = running;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Self-checking bench for dvi_timing_ctrl: a frame-position model checked every cycle plus
// directed literal checks on raster geometry, config handshake, drain and async reset.
module tb_dvi_timing_ctrl;

    localparam int CW = 12;

    logic            pix_clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [4*CW-1:0] cfg_h = '0;
    logic [4*CW-1:0] cfg_v = '0;
    logic            cfg_ready, cfg_err, pix_req, de, hsync, vsync, frame_start, busy;
    logic [CW-1:0]   pix_x, pix_y;

    int checks = 0;
    int errors = 0;

    dvi_timing_ctrl #(.CW(CW)) dut (
        .pix_clk     (pix_clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_h       (cfg_h),
        .cfg_v       (cfg_v),
        .cfg_err     (cfg_err),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pk(input int t, input int se, input int ss, input int a);
        return {t[11:0], se[11:0], ss[11:0], a[11:0]};
    endfunction

    function automatic bit legal(input logic [47:0] c, input int min_total);
        int a, ss, se, t;
        a  = int'(c[11:0]);
        ss = int'(c[23:12]);
        se = int'(c[35:24]);
        t  = int'(c[47:36]);
        return (a >= 1) && (a <= ss) && (ss < se) && (se <= t) && (t >= min_total);
    endfunction

    // Model: the raster is a linear position within the frame; each cycle's position and
    // timing set is snapshotted and the outputs are derived from snapshots 1 and 2 cycles old.
    typedef struct {
        bit busy;
        int h, v, ah, av, ssh, seh, ssv, sev;
    } snap_t;

    int    a_h[4], a_v[4], s_h[4], s_v[4];
    bit    s_full, m_busy, m_stop, m_err;
    int    pos, m_px, m_py;
    snap_t st1, st2;

    function automatic bit in_act(input snap_t s);
        return s.busy && (s.h < s.ah) && (s.v < s.av);
    endfunction

    task automatic model_reset();
        a_h = '{640, 656, 752, 800};
        a_v = '{480, 490, 492, 525};
        s_full = 0; m_busy = 0; m_stop = 0; m_err = 0;
        pos = 0; m_px = 0; m_py = 0;
        st1 = '{default: 0};
        st2 = '{default: 0};
    endtask

    task automatic model_step();
        snap_t cur;
        bit    fe, apply, hs;
        int    th, tv;
        th = a_h[3];
        tv = a_v[3];
        cur.busy = m_busy;
        cur.h = pos % th;
        cur.v = pos / th;
        cur.ah = a_h[0]; cur.ssh = a_h[1]; cur.seh = a_h[2];
        cur.av = a_v[0]; cur.ssv = a_v[1]; cur.sev = a_v[2];
        fe = m_busy && (pos == th * tv - 1);
        st2 = st1;
        st1 = cur;
        if (in_act(cur)) begin
            m_px = cur.h;
            m_py = cur.v;
        end
        apply = s_full && (fe || !m_busy);
        hs = cfg_valid && !s_full;
        m_err = 0;
        if (apply) begin
            a_h = s_h;
            a_v = s_v;
            s_full = 0;
        end
        if (hs) begin
            if (legal(cfg_h, 4) && legal(cfg_v, 2)) begin
                for (int i = 0; i < 4; i++) begin
                    s_h[i] = int'(cfg_h[i*12 +: 12]);
                    s_v[i] = int'(cfg_v[i*12 +: 12]);
                end
                s_full = 1;
            end else begin
                m_err = 1;
            end
        end
        if (m_busy) begin
            pos = fe ? 0 : pos + 1;
            if (m_stop && !en && fe) m_busy = 0;
            m_stop = !en;
        end else begin
            pos = 0;
            m_busy = en;
            m_stop = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pix_clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge pix_clk);
            chk("m_busy", int'(busy), int'(m_busy));
            chk("m_cfg_ready", int'(cfg_ready), int'(!s_full));
            chk("m_cfg_err", int'(cfg_err), int'(m_err));
            chk("m_pix_req", int'(pix_req), int'(in_act(st1)));
            chk("m_pix_x", int'(pix_x), m_px);
            chk("m_pix_y", int'(pix_y), m_py);
            chk("m_de", int'(de), int'(in_act(st2)));
            chk("m_hsync", int'(hsync),
                int'(st2.busy && st2.h >= st2.ssh && st2.h < st2.seh));
            chk("m_vsync", int'(vsync),
                int'(st2.busy && st2.v >= st2.ssv && st2.v < st2.sev));
            chk("m_frame_start", int'(frame_start),
                int'(in_act(st2) && st2.h == 0 && st2.v == 0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic offer(input logic [47:0] h, input logic [47:0] v);
        cfg_valid = 1'b1;
        cfg_h = h;
        cfg_v = v;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic measure_line(output int lat, output int dcnt, output int hcnt,
                                output int de_next);
        int n;
        n = 0;
        @(negedge pix_clk);
        while (!busy && n < 10) begin
            n++;
            @(negedge pix_clk);
        end
        lat = 0;
        while (!de && lat < 10) begin
            lat++;
            @(negedge pix_clk);
        end
        dcnt = 0;
        hcnt = 0;
        for (int i = 0; i < 800; i++) begin
            dcnt += int'(de);
            hcnt += int'(hsync);
            @(negedge pix_clk);
        end
        de_next = int'(de);
    endtask

    logic [47:0] bad_h[5], bad_v[5];
    logic [47:0] a_cfg_h, a_cfg_v, b_cfg_h, b_cfg_v;
    int lat, dcnt, hcnt, de_next, n, fs, drops;

    initial begin
        a_cfg_h = pk(12, 10, 8, 5);
        a_cfg_v = pk(8, 6, 5, 4);
        b_cfg_h = pk(8, 7, 6, 4);
        b_cfg_v = pk(6, 5, 4, 3);
        bad_h[0] = pk(12, 8, 8, 5);   bad_v[0] = a_cfg_v;
        bad_h[1] = pk(3, 3, 2, 1);    bad_v[1] = a_cfg_v;
        bad_h[2] = a_cfg_h;           bad_v[2] = pk(8, 6, 5, 0);
        bad_h[3] = a_cfg_h;           bad_v[3] = pk(8, 9, 5, 4);
        bad_h[4] = pk(12, 10, 8, 9);  bad_v[4] = a_cfg_v;

        repeat (3) tick();
        @(negedge pix_clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_de", int'(de), 0);
        chk("rst_pix_req", int'(pix_req), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Default 640x480 raster, first line geometry.
        en = 1'b1;
        measure_line(lat, dcnt, hcnt, de_next);
        chk("first_de_latency", lat, 2);
        chk("de_per_line", dcnt, 640);
        chk("hsync_per_line", hcnt, 96);
        chk("line_period", de_next, 1);

        // Offer mid-frame, then reset with the shadow still full.
        offer(b_cfg_h, b_cfg_v);
        @(negedge pix_clk);
        chk("accept_ready_low", int'(cfg_ready), 0);
        repeat (20) tick();
        @(posedge pix_clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_de", int'(de), 0);
        chk("async_pix_req", int'(pix_req), 0);
        chk("async_cfg_ready", int'(cfg_ready), 1);
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge pix_clk);
        chk("post_rst_ready", int'(cfg_ready), 1);
        en = 1'b1;
        measure_line(lat, dcnt, hcnt, de_next);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_de_per_line", dcnt, 640);
        chk("post_rst_hsync", hcnt, 96);
        tick();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Load a 12x8 raster while idle: applied on the following cycle.
        offer(a_cfg_h, a_cfg_v);
        @(negedge pix_clk);
        chk("idle_load_ready_low", int'(cfg_ready), 0);
        @(negedge pix_clk);
        chk("idle_load_ready_back", int'(cfg_ready), 1);

        for (int i = 0; i < 5; i++) begin
            offer(bad_h[i], bad_v[i]);
            @(negedge pix_clk);
            chk("illegal_err_pulse", int'(cfg_err), 1);
            chk("illegal_ready", int'(cfg_ready), 1);
            @(negedge pix_clk);
            chk("illegal_err_clear", int'(cfg_err), 0);
        end

        // Run 12x8, switch to 8x6 mid-frame.
        tick();
        en = 1'b1;
        repeat (30) tick();
        offer(b_cfg_h, b_cfg_v);
        @(negedge pix_clk);
        chk("mid_ready_low", int'(cfg_ready), 0);
        n = 0;
        while (!cfg_ready && n < 300) begin
            @(negedge pix_clk);
            n++;
        end
        chk("apply_seen", int'(n < 300), 1);
        n = 0;
        while (!frame_start && n < 100) begin
            @(negedge pix_clk);
            n++;
        end
        chk("fs_after_apply", n, 2);
        dcnt = 0;
        fs = 0;
        for (int i = 0; i < 48; i++) begin
            dcnt += int'(de);
            fs += int'(frame_start);
            @(negedge pix_clk);
        end
        chk("b_de_per_frame", dcnt, 12);
        chk("b_fs_per_frame", fs, 1);
        chk("b_frame_period", int'(frame_start), 1);

        // Stop request 1 cycle after frame_start: drains to frame end.
        tick();
        en = 1'b0;
        n = 0;
        @(negedge pix_clk);
        while (busy && n < 200) begin
            n++;
            @(negedge pix_clk);
        end
        chk("drain_busy_cycles", n, 45);
        chk("drain_hsync_flush", int'(hsync), 1);
        repeat (2) @(negedge pix_clk);
        chk("idle_de", int'(de), 0);
        chk("idle_hsync", int'(hsync), 0);
        chk("idle_vsync", int'(vsync), 0);

        // Re-assert en while draining: no gap in busy.
        tick();
        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        drops = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pix_clk);
            drops += int'(!busy);
        end
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge pix_clk);
            drops += int'(!busy);
        end
        chk("redrive_no_gap", drops, 0);
        tick();
        en = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge pix_clk);
            n++;
        end
        chk("final_idle", int'(busy), 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
